// File: rtl/mbm_pkg.sv
// Shared widths and rounding helper for the Mitchell antilog stage.
package mbm_pkg;

  localparam int MBM_N_DEF = 8;
  localparam int MBM_L_DEF = 3;

  function automatic int char_w(input int l);
    return l + 1;
  endfunction

  function automatic int prod_w(input int n);
    return 2 * n;
  endfunction

  function automatic int shift_w(input int n);
    return 3 * n - 1;
  endfunction

  // Half an output LSB, only when low bits are about to be shifted out.
  function automatic logic [63:0] rnd_const(input int n, input int e);
    if (e < n - 1) return 64'(1) << (n - 2);
    else           return '0;
  endfunction

  localparam int MBM_CHAR_W  = char_w(MBM_L_DEF);
  localparam int MBM_PROD_W  = prod_w(MBM_N_DEF);
  localparam int MBM_SHIFT_W = shift_w(MBM_N_DEF);

endpackage

// File: rtl/mbm_barrel_shift.sv
// Antilog shift: product = (m << e) >> (N-1), zero-forced.
// MBM_ROUND_EN selects round-to-nearest (ties up) instead of truncation.
module mbm_barrel_shift
  import mbm_pkg::*;
#(
  parameter int N = MBM_N_DEF,
  parameter int L = MBM_L_DEF
) (
  input  logic [N-1:0]   m,
  input  logic [L:0]     e,
  input  logic           zero,
  output logic [2*N-1:0] product
);

  localparam int SW = shift_w(N);
  localparam int PW = prod_w(N);

  logic [SW-1:0] wide;

  always_comb begin
    wide = SW'(m) << e;
`ifdef MBM_ROUND_EN
    wide = wide + SW'(rnd_const(N, int'(e)));
`else
    wide = wide;
`endif
    product = zero ? '0 : PW'(wide >> (N - 1));
  end

endmodule

// File: rtl/mbm_antilog_stage.sv
// Two-stage elastic antilog pipeline: exponent/mantissa register, then shifted product.
// Rounding mode follows MBM_ROUND_EN inside mbm_barrel_shift; handshake is identical.
module mbm_antilog_stage
  import mbm_pkg::*;
#(
  parameter int N = MBM_N_DEF,
  parameter int L = MBM_L_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [L:0]     k_sum,
  input  logic           carry,
  input  logic [N-2:0]   fractional,
  input  logic           zero_in,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] product
);

  localparam int CW = char_w(L);
  localparam int PW = prod_w(N);

  logic [2:1]    vld_pipe;
  logic [CW-1:0] e_q;
  logic [N-1:0]  m_q;
  logic          zero_q;
  logic          ld1, ld2;
  logic [PW-1:0] shifted;

  // A stage loads when empty or when its occupant moves on this cycle.
  assign ld2       = !vld_pipe[2] || out_ready;
  assign ld1       = !vld_pipe[1] || ld2;
  assign in_ready  = rst_n && ld1;
  assign out_valid = vld_pipe[2];

  mbm_barrel_shift #(.N(N), .L(L)) u_shift (
    .m       (m_q),
    .e       (e_q),
    .zero    (zero_q),
    .product (shifted)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      e_q      <= '0;
      m_q      <= '0;
      zero_q   <= 1'b0;
      product  <= '0;
    end else begin
      if (ld1) begin
        vld_pipe[1] <= in_valid;
        if (in_valid) begin
          e_q    <= k_sum + CW'(carry);
          m_q    <= {1'b1, fractional};
          zero_q <= zero_in;
        end
      end
      if (ld2) begin
        vld_pipe[2] <= vld_pipe[1];
        if (vld_pipe[1]) product <= shifted;
      end
    end
  end

endmodule

// File: tb/tb_mbm_antilog_stage.sv
// Scoreboard bench for mbm_antilog_stage: directed corner cases, stall, reset flush, random traffic.
module tb_mbm_antilog_stage;

  localparam int N = 8;
  localparam int L = 3;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [L:0]     k_sum = '0;
  logic           carry = 1'b0;
  logic [N-2:0]   fractional = '0;
  logic           zero_in = 1'b0;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [2*N-1:0] product;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];

  mbm_antilog_stage #(.N(N), .L(L)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .k_sum      (k_sum),
    .carry      (carry),
    .fractional (fractional),
    .zero_in    (zero_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .product    (product)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Mitchell antilog from the arithmetic definition: (1.f) * 2^e, scaled to integer.
  function automatic logic [15:0] model(input int k, input int c, input int f, input bit z);
    longint e, v;
    if (z) return 16'd0;
    e = k + c;
    v = longint'(128 + f) * (longint'(1) << e);
`ifdef MBM_ROUND_EN
    if (e < 7) v = v + 64;
`endif
    return 16'((v / 128) % 65536);
  endfunction

  task automatic send(input int k, input int c, input int f, input bit z, input logic [15:0] exp);
    int n;
    n = 0;
    in_valid   = 1'b1;
    k_sum      = 4'(k);
    carry      = 1'(c);
    fractional = 7'(f);
    zero_in    = z;
    forever begin
      #1;
      if (in_ready) begin
        exp_q.push_back(exp);
        @(negedge clk);
        break;
      end
      @(negedge clk);
      n++;
      if (n > 50) begin
        checks++;
        errors++;
        $display("FAIL send_timeout: got in_ready 0 expected 1 within 50 cycles");
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  // Monitor: pops on every output transfer and checks hold-stability under backpressure.
  initial begin
    bit          stall;
    logic [15:0] held;
    stall = 1'b0;
    held  = '0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        stall = 1'b0;
        continue;
      end
      if (stall) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_product", 32'(product), 32'(held));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got product %0h expected no output", product);
        end else begin
          check("product", 32'(product), 32'(exp_q.pop_front()));
        end
      end
      stall = out_valid && !out_ready;
      held  = product;
    end
  end

  initial begin
    int acc;
    int n;
    fork
      begin
        #1_000_000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
      end
    join_none

    repeat (3) @(negedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_product", 32'(product), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("ready_after_reset", 32'(in_ready), 32'd1);
    check("valid_after_reset", 32'(out_valid), 32'd0);
    @(negedge clk);

    // Latency with out_ready held high.
    out_ready = 1'b1;
    send(3, 0, 0, 0, 16'd8);
    #1;
    check("lat_cycle1", 32'(out_valid), 32'd0);
    @(negedge clk);
    #1;
    check("lat_cycle2", 32'(out_valid), 32'd1);
    @(negedge clk);

    send(14, 1, 7'h7F, 0, 16'hFF00);
`ifdef MBM_ROUND_EN
    send(0, 0, 7'h40, 0, 16'd2);
`else
    send(0, 0, 7'h40, 0, 16'd1);
`endif
    send(9, 0, 7'h55, 1, 16'd0);
    repeat (4) @(negedge clk);

    // Backpressure: 3 cycles with out_ready low, only 2 accepts fit.
    out_ready = 1'b0;
    acc = 0;
    for (int cyc = 0; cyc < 3; cyc++) begin
      in_valid   = 1'b1;
      k_sum      = 4'(acc + 2);
      carry      = 1'b0;
      fractional = 7'(acc * 21);
      zero_in    = 1'b0;
      #1;
      if (cyc == 2) check("stall_in_ready", 32'(in_ready), 32'd0);
      if (in_ready) begin
        exp_q.push_back(model(acc + 2, 0, acc * 21, 1'b0));
        acc++;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("stall_accepts", 32'(acc), 32'd2);
    out_ready = 1'b1;
    while (acc < 4) begin
      send(acc + 2, 0, acc * 21, 1'b0, model(acc + 2, 0, acc * 21, 1'b0));
      acc++;
    end
    repeat (5) @(negedge clk);

    // Reset with two entries in flight.
    out_ready = 1'b0;
    send(5, 1, 7'h11, 0, model(5, 1, 7'h11, 1'b0));
    send(6, 0, 7'h22, 0, model(6, 0, 7'h22, 1'b0));
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("postrst_in_ready", 32'(in_ready), 32'd1);
    check("postrst_out_valid", 32'(out_valid), 32'd0);
    out_ready = 1'b1;
    repeat (4) @(negedge clk);

    // Random traffic with random backpressure.
    for (int i = 0; i < 400; i++) begin
      out_ready = ($urandom % 4) != 0;
      if (($urandom % 4) != 0) begin
        int k, c, f;
        bit z;
        k = $urandom_range(0, 14);
        c = $urandom_range(0, 1);
        f = $urandom_range(0, 127);
        z = ($urandom % 8) == 0;
        in_valid   = 1'b1;
        k_sum      = 4'(k);
        carry      = 1'(c);
        fractional = 7'(f);
        zero_in    = z;
        #1;
        if (in_ready) exp_q.push_back(model(k, c, f, z));
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    check("drain_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
